slicer_ref_ctrl: RTL

// - Adaptive reference-level controller for the 4-ASK slicer.
// - Averages |in| over windows of 2^LOG2_N symbols and drives the slicer ref_level input.
// - For equiprobable levels +/-A, +/-3A, mean |x| = 2A, which is the outer decision threshold.
// - Sits between the matched-filter/downsampler output and the slicer; sequences acquire/track/freeze.

---
 rtl/slicer_ref_ctrl_pkg.sv | 14 +
 rtl/slicer_ref_ctrl_abs_accum.sv | 33 +++
 rtl/slicer_ref_ctrl.sv | 77 +++++++
 3 files changed

// File: rtl/slicer_ref_ctrl_pkg.sv
// slicer_ref_ctrl_pkg: sample format, FSM states and helpers shared by the reference controller
package slicer_ref_ctrl_pkg;
  localparam int SAMPLE_W = 18;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] REF_MIN_DEF = 18'sd256;
  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;
  function automatic logic [SAMPLE_W-1:0] sat_abs(input logic signed [SAMPLE_W-1:0] x);
    return x == SAMPLE_MIN ? SAMPLE_W'(SAMPLE_MAX) : x < 0 ? SAMPLE_W'(-x) : SAMPLE_W'(x);
  endfunction
  function automatic logic signed [SAMPLE_W-1:0] floor_ref(input logic signed [SAMPLE_W-1:0] c, input logic signed [SAMPLE_W-1:0] m);
    return c < m ? m : c;
  endfunction
endpackage

// File: rtl/slicer_ref_ctrl_abs_accum.sv
// slicer_ref_ctrl_abs_accum: saturating |in| accumulator over 2^LOG2_N-sample windows
module slicer_ref_ctrl_abs_accum
  import slicer_ref_ctrl_pkg::*;
#(
  parameter int LOG2_N = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       sample,
  input  logic signed [SAMPLE_W-1:0] in,
  output logic signed [SAMPLE_W-1:0] mean,
  output logic                       win_done
);
  localparam int AW = SAMPLE_W + LOG2_N;
  logic [AW-1:0] acc, sum;
  logic [LOG2_N-1:0] win_cnt;
  assign sum = acc + AW'(sat_abs(in));
  assign mean = SAMPLE_W'(sum >> LOG2_N);
  assign win_done = sample && &win_cnt;
  // accumulate sampled magnitudes; restart after the last sample of a window or when idle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      acc <= '0;
      win_cnt <= '0;
    end else if (clr || win_done) begin
      acc <= '0;
      win_cnt <= '0;
    end else if (sample) begin
      acc <= sum;
      win_cnt <= win_cnt + 1'b1;
    end
endmodule

// File: rtl/slicer_ref_ctrl.sv
// slicer_ref_ctrl: adaptive 4-ASK slicer reference level (define SLICER_REF_IIR_EN for IIR smoothing in TRACK)
module slicer_ref_ctrl
  import slicer_ref_ctrl_pkg::*;
#(
  parameter int                         LOG2_N      = 4,
  parameter int                         ACQ_WINDOWS = 4,
  parameter logic signed [SAMPLE_W-1:0] REF_INIT    = 18'sd32768,
  parameter logic signed [SAMPLE_W-1:0] REF_MIN     = REF_MIN_DEF,
  parameter int                         IIR_SHIFT   = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clk_en,
  input  logic                       enable,
  input  logic                       freeze,
  input  logic signed [SAMPLE_W-1:0] in,
  output logic signed [SAMPLE_W-1:0] ref_level,
  output logic                       ref_valid,
  output logic                       ref_update,
  output logic                       locked
);
`ifdef SLICER_REF_IIR_EN
  localparam bit IIR_EN = 1'b1;
`else
  localparam bit IIR_EN = 1'b0;
`endif
  localparam int AQW = $clog2(ACQ_WINDOWS + 1);
  state_t state;
  logic [AQW-1:0] acq_cnt;
  logic signed [SAMPLE_W-1:0] mean, cand;
  logic signed [SAMPLE_W:0] diff, step;
  logic sample, win_done;
  assign sample = clk_en && enable && (state == ACQUIRE || (state == TRACK && !freeze));
  assign diff = {mean[SAMPLE_W-1], mean} - {ref_level[SAMPLE_W-1], ref_level};
  assign step = diff >>> IIR_SHIFT;
  assign cand = (IIR_EN && state == TRACK) ? ref_level + SAMPLE_W'(step) : mean;
  slicer_ref_ctrl_abs_accum #(.LOG2_N(LOG2_N)) u_accum (
    .clk(clk),
    .reset_n(reset_n),
    .clr(!enable || state == IDLE),
    .sample(sample),
    .in(in),
    .mean(mean),
    .win_done(win_done)
  );
  // acquire/track/idle sequencing and the registered reference outputs
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      acq_cnt <= '0;
      ref_level <= REF_INIT;
      ref_valid <= 1'b0;
      ref_update <= 1'b0;
      locked <= 1'b0;
    end else begin
      ref_update <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        acq_cnt <= '0;
        locked <= 1'b0;
      end else if (clk_en) begin
        if (state == IDLE) state <= ACQUIRE;
        if (win_done) begin
          ref_level <= floor_ref(cand, REF_MIN);
          ref_valid <= 1'b1;
          ref_update <= 1'b1;
        end
        if (win_done && state == ACQUIRE) begin
          acq_cnt <= acq_cnt + 1'b1;
          if (acq_cnt == AQW'(ACQ_WINDOWS - 1)) begin
            state <= TRACK;
            locked <= 1'b1;
          end
        end
      end
    end
endmodule
